lsu_mem_port: RTL

- Executes the memory accesses that the instruction decoder requests; it is the consumer of the decoder's mem_wEn, MemSize, load_extend_sign and wb_sel outputs.
- Sits between the execute/ALU stage and a word-wide data-memory bus that uses a request/grant plus response-valid handshake.
- Performs byte-lane steering, write-strobe generation, load extraction with sign/zero extension, and misalignment checking.
- Stalls the pipeline until each access completes or faults.

---
 rtl/lsu_mem_port_pkg.sv | 26 ++
 rtl/lsu_lane_align.sv | 53 +++++
 rtl/lsu_mem_port.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_pkg.sv
// rtl/lsu_mem_port_pkg.sv - shared size codes, FSM states and access legality check
package lsu_mem_port_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HWORD = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RESP = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } lsu_state_t;

    // An access is rejected for the reserved size code or a size/lane mismatch.
    function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE:  access_illegal = 1'b0;
            SIZE_HWORD: access_illegal = lane[0];
            SIZE_WORD:  access_illegal = |lane;
            default:    access_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - store lane replication/byte enables and load extract/extend
module lsu_lane_align
    import lsu_mem_port_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] store_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_sign,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store: replicate the operand across all lanes, enable only the addressed ones
    always_comb begin
        st_wdata = store_data;
        st_be    = 4'b1111;
        case (st_size)
            SIZE_BYTE: begin
                st_wdata = {4{store_data[7:0]}};
                st_be    = 4'b0001 << st_lane;
            end
            SIZE_HWORD: begin
                st_wdata = {2{store_data[15:0]}};
                st_be    = st_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Load: pick the addressed byte/halfword and extend it; words pass through
    always_comb begin
        case (ld_lane)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_lane[1] ? rdata[31:16] : rdata[15:0];
        case (ld_size)
            SIZE_BYTE:  ld_data = {{24{ld_sign & ld_byte[7]}}, ld_byte};
            SIZE_HWORD: ld_data = {{16{ld_sign & ld_half[15]}}, ld_half};
            default:    ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit data-memory port with stall, timeout and misalign checks
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        mem_wEn,
    input  logic        is_load,
    input  logic [1:0]  MemSize,
    input  logic        load_extend_sign,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        bus_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TMO_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);

    lsu_state_t    state, state_n;
    logic [CW-1:0] tmo_cnt;
    logic          access, illegal, timed_out;
    logic          op_store, op_sign, err_misalign;
    logic [1:0]    op_size, op_lane;
    logic [31:0]   st_wdata, ld_ext;
    logic [3:0]    st_be;

    // A store wins when the decoder asserts both store and load.
    assign access    = req_valid & (~mem_wEn | is_load);
    assign illegal   = access_illegal(MemSize, addr[1:0]);
    // The current cycle is the last one allowed in REQ+RESP.
    assign timed_out = (tmo_cnt >= TMO_LAST);

    lsu_lane_align u_align (
        .st_size    (MemSize),
        .st_lane    (addr[1:0]),
        .store_data (store_data),
        .st_wdata   (st_wdata),
        .st_be      (st_be),
        .ld_size    (op_size),
        .ld_lane    (op_lane),
        .ld_sign    (op_sign),
        .rdata      (bus_rdata),
        .ld_data    (ld_ext)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Next state plus stall/done/status decode; a bus handshake beats a same-cycle timeout
    always_comb begin
        state_n   = state;
        stall     = 1'b0;
        done      = 1'b0;
        misalign  = 1'b0;
        bus_fault = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    stall   = 1'b1;
                    state_n = illegal ? ST_ERR : ST_REQ;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (bus_gnt)        state_n = ST_RESP;
                else if (timed_out) state_n = ST_ERR;
            end
            ST_RESP: begin
                stall = 1'b1;
                if (bus_rvalid)     state_n = ST_DONE;
                else if (timed_out) state_n = ST_ERR;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            ST_ERR: begin
                done      = 1'b1;
                misalign  = err_misalign;
                bus_fault = ~err_misalign;
                state_n   = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        if (reset) stall = 1'b0;
    end

    // Bus request fields, operand capture for the response, load result and timeout counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_be       <= '0;
            load_data    <= '0;
            tmo_cnt      <= '0;
            op_store     <= 1'b0;
            op_sign      <= 1'b0;
            op_size      <= '0;
            op_lane      <= '0;
            err_misalign <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        op_store     <= ~mem_wEn;
                        op_sign      <= load_extend_sign;
                        op_size      <= MemSize;
                        op_lane      <= addr[1:0];
                        err_misalign <= illegal;
                        load_data    <= '0;
                        tmo_cnt      <= '0;
                        if (!illegal) begin
                            bus_req   <= 1'b1;
                            bus_we    <= ~mem_wEn;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wdata <= st_wdata;
                            bus_be    <= st_be;
                        end
                    end
                end
                ST_REQ: begin
                    if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + CW'(1);
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                    end else if (timed_out) begin
                        bus_req      <= 1'b0;
                        err_misalign <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + CW'(1);
                    if (bus_rvalid)     load_data    <= op_store ? 32'h0 : ld_ext;
                    else if (timed_out) err_misalign <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
